// File: rtl/pio_poll_master.sv
// Periodic Avalon-MM read initiator for a read-only PIO slave at word 0.
// Debounces the sampled field across consecutive polls and reports stable changes.
module pio_poll_master #(
  parameter int DATA_W       = 16,
  parameter int POLL_DIV     = 1000,
  parameter int STABLE_POLLS = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] sw_value,
  output logic              sw_valid,
  output logic              sw_changed,
  output logic              busy
);

  localparam int TIMER_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);
  localparam int SC_W    = $clog2(STABLE_POLLS + 1);

  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0]   LAT_MAX    = LAT_W'(READ_LATENCY);
  localparam logic [SC_W-1:0]    STABLE_MAX = SC_W'(STABLE_POLLS);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t              state_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [DATA_W-1:0]   cand_reg;
  logic [SC_W-1:0]     stable_cnt_reg;

  logic [DATA_W-1:0]   sample;
  logic [DATA_W-1:0]   cand_next;
  logic [SC_W-1:0]     stable_next;
  logic                update;
  logic                unused_bits;

  assign avm_address = 2'b00;
  assign sample      = avm_readdata[DATA_W-1:0];
  assign unused_bits = ^avm_readdata;

  // Post-update candidate/count, applied only on the sampling edge.
  always_comb begin
    cand_next   = cand_reg;
    stable_next = stable_cnt_reg;
    if (sample == cand_reg) begin
      if (stable_cnt_reg != STABLE_MAX)
        stable_next = stable_cnt_reg + SC_W'(1);
    end else begin
      cand_next   = sample;
      stable_next = SC_W'(1);
    end
    update = (stable_next == STABLE_MAX) && (!sw_valid || (cand_next != sw_value));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      lat_cnt_reg    <= '0;
      cand_reg       <= '0;
      stable_cnt_reg <= '0;
      avm_read       <= 1'b0;
      sw_value       <= '0;
      sw_valid       <= 1'b0;
      sw_changed     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Dropping enable restarts the interval rather than pausing it.
          if (!enable) begin
            timer_reg <= '0;
          end else if (timer_reg == TIMER_MAX) begin
            timer_reg <= '0;
            state_reg <= READ;
            avm_read  <= 1'b1;
            busy      <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        READ: begin
          avm_read    <= 1'b0;
          lat_cnt_reg <= LAT_W'(1);
          state_reg   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt_reg == LAT_MAX) begin
            cand_reg       <= cand_next;
            stable_cnt_reg <= stable_next;
            if (update) begin
              sw_value   <= cand_next;
              sw_valid   <= 1'b1;
              sw_changed <= 1'b1;
            end
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          avm_read  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
